// File: rtl/color_effects_controller.sv
// color_effects_controller: frame-driven hue rotation, beat-synchronous luminance pulse
// and periodic colour inversion for the VGA colour mapper, keyed off the game state.
module color_effects_controller #(
   parameter int BEAT_FRAMES  = 30,
   parameter int PULSE_AMP    = 3,
   parameter int INVERT_BEATS = 8
) (
   input  logic       Clk,
   input  logic       Reset,
   input  logic       frame_tick,
   input  logic [2:0] State,
   output logic [5:0] Hue_offset,
   output logic [4:0] Saturation_offset,
   output logic [4:0] Luminance_offset,
   output logic       invert_colors
);
   localparam int CW = BEAT_FRAMES > 1 ? $clog2(BEAT_FRAMES) : 1;
   localparam int IW = INVERT_BEATS > 1 ? $clog2(INVERT_BEATS) : 1;
   localparam logic [CW-1:0] BEAT_LAST = CW'(BEAT_FRAMES - 1);
   localparam logic [IW-1:0] IDX_LAST = IW'(INVERT_BEATS - 1);
   localparam logic [4:0] AMP = 5'(PULSE_AMP);
   logic [1:0] hue_div;
   logic [CW-1:0] beat_cnt;
   logic [IW-1:0] beat_idx;
   logic [2:0] prev_state;
   logic decay_ph, armed;
   logic playing, over, start, beat, hue_en;
   assign Saturation_offset = '0;
   assign playing = State != 3'd0 && State < 3'd4;
   assign over = State >= 3'd4;
   // armed stays low for the first edge after reset so a State already at 1 is not a game start
   assign start = armed && prev_state == 3'd0 && State == 3'd1;
   assign beat = frame_tick && playing && beat_cnt == BEAT_LAST;
   assign hue_en = (State == 3'd0 || State == 3'd2) ? !hue_div[0] :
                   State == 3'd1 ? hue_div == 2'd0 : State == 3'd3;
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         Hue_offset <= '0;
         Luminance_offset <= '0;
         invert_colors <= 1'b0;
         hue_div <= '0;
         beat_cnt <= '0;
         beat_idx <= '0;
         decay_ph <= 1'b0;
         prev_state <= '0;
         armed <= 1'b0;
      end else begin
         armed <= 1'b1;
         prev_state <= State;
         if (start) begin
            Luminance_offset <= AMP;
            beat_cnt <= '0;
            hue_div <= '0;
            decay_ph <= 1'b0;
            beat_idx <= '0;
            invert_colors <= 1'b0;
         end else begin
            if (frame_tick) begin
               hue_div <= hue_div + 2'd1;
               if (hue_en) Hue_offset <= Hue_offset + 6'd1;
            end
            beat_cnt <= !playing ? '0 : !frame_tick ? beat_cnt :
                        beat_cnt == BEAT_LAST ? '0 : beat_cnt + CW'(1);
            if (over) begin
               Luminance_offset <= '0;
               decay_ph <= 1'b0;
            end else if (beat) begin
               Luminance_offset <= AMP;
               decay_ph <= 1'b0;
            end else if (frame_tick) begin
               decay_ph <= !decay_ph;
               if (decay_ph && Luminance_offset != 5'd0) Luminance_offset <= Luminance_offset - 5'd1;
            end
            if (State != 3'd3) begin
               beat_idx <= '0;
               invert_colors <= 1'b0;
            end else if (beat) begin
               beat_idx <= beat_idx == IDX_LAST ? '0 : beat_idx + IW'(1);
               if (beat_idx == IDX_LAST) invert_colors <= !invert_colors;
            end
         end
      end
   end
endmodule

// File: tb/tb_color_effects_controller.sv
// tb_color_effects_controller: directed vectors; expectations are queued by the stimulus
// and checked by an independent negedge monitor.
module tb_color_effects_controller;
   logic clk = 1'b0;
   logic rst_n;
   logic frame_tick;
   logic [2:0] state;
   logic [5:0] hue;
   logic [4:0] sat, lum;
   logic inv;
   typedef struct {
      string name;
      logic [5:0] hue;
      logic [4:0] lum;
      logic inv;
   } exp_t;
   exp_t q[$];
   int tests = 0;
   int fails = 0;
   color_effects_controller dut (
      .Clk(clk),
      .Reset(rst_n),
      .frame_tick(frame_tick),
      .State(state),
      .Hue_offset(hue),
      .Saturation_offset(sat),
      .Luminance_offset(lum),
      .invert_colors(inv)
   );
   always #5 clk = !clk;
   initial forever begin
      @(negedge clk);
      while (q.size() > 0) begin
         exp_t e;
         e = q.pop_front();
         tests++;
         if (hue !== e.hue || lum !== e.lum || inv !== e.inv || sat !== 5'd0) begin
            fails++;
            $display("FAIL %s: got hue=%0d sat=%0d lum=%0d inv=%0b, want hue=%0d sat=0 lum=%0d inv=%0b",
                     e.name, hue, sat, lum, inv, e.hue, e.lum, e.inv);
         end
      end
   end
   task automatic chk(input string name, input int h, input int l, input bit i);
      exp_t e;
      e.name = name;
      e.hue = 6'(h);
      e.lum = 5'(l);
      e.inv = i;
      q.push_back(e);
   endtask
   task automatic cyc(input logic t, input logic [2:0] s, input int n);
      for (int k = 0; k < n; k++) begin
         @(negedge clk);
         frame_tick = t;
         state = s;
         @(posedge clk);
      end
   endtask
   task automatic do_reset();
      @(negedge clk);
      #1;
      rst_n = 1'b0;
      frame_tick = 1'b0;
      state = 3'd0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask
   initial begin
      rst_n = 1'b0;
      frame_tick = 1'b0;
      state = 3'd0;
      chk("reset", 0, 0, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      cyc(1, 0, 8);
      chk("s0_8ticks", 4, 0, 0);
      do_reset();
      cyc(0, 0, 1);
      cyc(0, 1, 1);
      chk("game_start", 0, 3, 0);
      cyc(1, 1, 2);
      chk("decay_2", 1, 2, 0);
      cyc(1, 1, 4);
      chk("decay_6", 2, 0, 0);
      cyc(1, 1, 23);
      chk("s1_29ticks", 8, 0, 0);
      cyc(1, 1, 1);
      chk("s1_beat30", 8, 3, 0);
      cyc(0, 3, 1);
      cyc(1, 3, 239);
      chk("s3_239ticks", 55, 0, 0);
      cyc(1, 3, 1);
      chk("s3_invert", 56, 3, 1);
      cyc(0, 2, 1);
      chk("s2_invert_clr", 56, 3, 0);
      do_reset();
      cyc(0, 0, 1);
      cyc(0, 1, 1);
      cyc(0, 3, 1);
      cyc(1, 3, 240);
      chk("s3_invert_b", 48, 3, 1);
      cyc(0, 4, 1);
      chk("game_over", 48, 0, 0);
      cyc(1, 4, 10);
      chk("over_hue_hold", 48, 0, 0);
      cyc(0, 0, 1);
      cyc(0, 1, 1);
      chk("restart", 48, 3, 0);
      cyc(0, 3, 1);
      cyc(1, 3, 15);
      chk("hue_63", 63, 0, 0);
      cyc(1, 3, 1);
      chk("hue_wrap", 0, 0, 0);
      cyc(1, 3, 14);
      chk("pre_async", 14, 3, 0);
      @(negedge clk);
      #1;
      frame_tick = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      state = 3'd1;
      chk("async_reset", 0, 0, 0);
      @(negedge clk);
      #1;
      rst_n = 1'b1;
      cyc(0, 1, 1);
      chk("no_start_after_rst", 0, 0, 0);
      cyc(0, 1, 2);
      chk("no_start_hold", 0, 0, 0);
      cyc(0, 0, 1);
      cyc(1, 1, 1);
      chk("start_with_tick", 0, 3, 0);
      cyc(1, 1, 29);
      chk("coinc_29", 8, 0, 0);
      cyc(1, 1, 1);
      chk("coinc_beat", 8, 3, 0);
      cyc(1, 0, 2);
      chk("s0_decay", 9, 2, 0);
      repeat (3) @(negedge clk);
      #1;
      if (q.size() != 0) begin
         tests++;
         fails++;
         $display("FAIL drain: got %0d pending, want 0", q.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
